// File: rtl/apu_pkg.sv
// Shared constants for the APU pulse channels.
//   LEN_TABLE  : length-counter load values, indexed by reg3[7:3]
//   DUTY_TABLE : 8-step duty waveforms, bit n = output level at sequencer step n
//   REG_*      : register offsets within one channel's 4-register window
package apu_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SWEEP = 2'd1;
  localparam logic [1:0] REG_LO    = 2'd2;
  localparam logic [1:0] REG_HI    = 2'd3;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40,  8'd4,  8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14,  8'd12, 8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48,  8'd20, 8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16,  8'd28, 8'd32,  8'd30
  };

  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0000_0001, 8'b0000_0011, 8'b0000_1111, 8'b1111_1100
  };

endpackage

// File: rtl/apu_pulse_ch.sv
// One NES-style pulse channel: register file, timer, duty sequencer,
// envelope, sweep and length counter.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   apu_tick             timer clock enable
//   qframe, hframe       frame-sequencer strobes
//   we, reg_sel, wdata   register write (we already qualified for this channel)
//   en                   channel enable; 0 clears and holds the length counter
//   level                gated output level (combinational, registered by the top)
//   active               length counter nonzero
module apu_pulse_ch
  import apu_pkg::*;
#(
  parameter int TW       = 11,
  parameter bit NEG_ONES = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_tick,
  input  logic       qframe,
  input  logic       hframe,
  input  logic       we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] wdata,
  input  logic       en,
  output logic [3:0] level,
  output logic       active
);

  logic [1:0]    duty;
  logic          halt;
  logic          const_vol;
  logic [3:0]    env_p;
  logic          sw_en;
  logic [2:0]    sw_p;
  logic          sw_neg;
  logic [2:0]    sw_shift;
  logic [TW-1:0] period;
  logic [TW-1:0] cnt;
  logic [2:0]    step;
  logic          env_start;
  logic [3:0]    env_div;
  logic [3:0]    decay;
  logic          sw_reload;
  logic [2:0]    sw_div;
  logic [7:0]    len;

  // Sweep target; the add path keeps a carry bit so overflow can mute.
  logic [TW-1:0] delta;
  logic [TW:0]   sum_add;
  logic [TW-1:0] target;
  logic          mute;

  assign delta   = period >> sw_shift;
  assign sum_add = {1'b0, period} + {1'b0, delta};
  assign target  = sw_neg ? (period - delta - TW'(NEG_ONES)) : sum_add[TW-1:0];
  assign mute    = (period < TW'(8)) | (~sw_neg & sum_add[TW]);

  // Period as written by the CPU; bits above 10 are always zero.
  logic [15:0]   p_wide;
  logic [TW-1:0] next_period;

  always_comb begin
    p_wide = 16'(period);
    if (reg_sel == REG_LO) begin
      p_wide[7:0] = wdata;
    end else begin
      p_wide[10:8]  = wdata[2:0];
      p_wide[15:11] = '0;
    end
    next_period = p_wide[TW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty      <= '0;
      halt      <= 1'b0;
      const_vol <= 1'b0;
      env_p     <= '0;
      sw_en     <= 1'b0;
      sw_p      <= '0;
      sw_neg    <= 1'b0;
      sw_shift  <= '0;
      period    <= '0;
      cnt       <= '0;
      step      <= '0;
      env_start <= 1'b0;
      env_div   <= '0;
      decay     <= '0;
      sw_reload <= 1'b0;
      sw_div    <= '0;
      len       <= '0;
    end else begin
      if (apu_tick) begin
        if (cnt == '0) begin
          cnt  <= period;
          step <= step - 3'd1;
        end else begin
          cnt <= cnt - TW'(1);
        end
      end

      if (qframe) begin
        if (env_start) begin
          env_start <= 1'b0;
          decay     <= 4'd15;
          env_div   <= env_p;
        end else if (env_div == 4'd0) begin
          env_div <= env_p;
          if (decay != 4'd0) decay <= decay - 4'd1;
          else if (halt)     decay <= 4'd15;
        end else begin
          env_div <= env_div - 4'd1;
        end
      end

      if (hframe) begin
        if (sw_div == 3'd0 && sw_en && sw_shift != 3'd0 && !mute) period <= target;
        if (sw_div == 3'd0 || sw_reload) begin
          sw_div    <= sw_p;
          sw_reload <= 1'b0;
        end else begin
          sw_div <= sw_div - 3'd1;
        end
        if (!halt && len != 8'd0) len <= len - 8'd1;
      end

      // NOTE: with non-blocking assignments the last one in the block wins,
      // so placing CPU writes (and the enable clear) after the tick/strobe
      // updates gives them priority without extra gating.
      if (we) begin
        case (reg_sel)
          REG_CTRL:  {duty, halt, const_vol, env_p} <= wdata;
          REG_SWEEP: begin
            {sw_en, sw_p, sw_neg, sw_shift} <= wdata;
            sw_reload <= 1'b1;
          end
          REG_LO:    period <= next_period;
          default: begin
            period    <= next_period;
            step      <= 3'd0;
            env_start <= 1'b1;
            if (en) len <= LEN_TABLE[wdata[7:3]];
          end
        endcase
      end

      if (!en) len <= 8'd0;
    end
  end

  logic gate;
  assign gate   = (len != 8'd0) & ~mute & DUTY_TABLE[duty][step];
  assign level  = gate ? (const_vol ? env_p : decay) : 4'd0;
  assign active = (len != 8'd0);

endmodule

// File: rtl/apu_pulse_array.sv
// Array of CH pulse channels sharing one clock and frame strobes.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   apu_tick          timer clock enable
//   qframe, hframe    quarter/half-frame strobes
//   we, addr, wdata   register write; addr = {channel, reg[1:0]}
//   en                per-channel enable
//   act               per-channel length-active flag (registered)
//   vol               per-channel level, channel i at [4i+3:4i] (registered)
//   mix               sum of all channel levels (registered)
module apu_pulse_array
  import apu_pkg::*;
#(
  parameter int            CH       = 2,
  parameter int            TW       = 11,
  parameter logic [CH-1:0] NEG_ONES = 2'b01,
  localparam int           AW       = $clog2(CH) + 2,
  localparam int           MW       = 4 + $clog2(CH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            apu_tick,
  input  logic            qframe,
  input  logic            hframe,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [7:0]      wdata,
  input  logic [CH-1:0]   en,
  output logic [CH-1:0]   act,
  output logic [4*CH-1:0] vol,
  output logic [MW-1:0]   mix
);

  logic [3:0]    level [CH];
  logic [CH-1:0] active;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = we && ((addr >> 2) == AW'(i));

    apu_pulse_ch #(
      .TW       (TW),
      .NEG_ONES (NEG_ONES[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .apu_tick (apu_tick),
      .qframe   (qframe),
      .hframe   (hframe),
      .we       (ch_we),
      .reg_sel  (addr[1:0]),
      .wdata    (wdata),
      .en       (en[i]),
      .level    (level[i]),
      .active   (active[i])
    );
  end

  logic [4*CH-1:0] vol_next;
  logic [MW-1:0]   mix_next;

  always_comb begin
    vol_next = '0;
    mix_next = '0;
    for (int i = 0; i < CH; i++) begin
      vol_next[4*i +: 4] = level[i];
      mix_next           = mix_next + MW'(level[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vol <= '0;
      mix <= '0;
      act <= '0;
    end else begin
      vol <= vol_next;
      mix <= mix_next;
      act <= active;
    end
  end

endmodule

// File: tb/tb_apu_pulse_array.sv
// Directed bench for apu_pulse_array (CH=2, TW=11, ch0 ones' / ch1 twos'
// complement sweep negate). Expected values are hand-computed constants.
module tb_apu_pulse_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       apu_tick;
  logic       qframe;
  logic       hframe;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [1:0] en;
  logic [1:0] act;
  logic [7:0] vol;
  logic [5:0] mix;

  int vectors = 0;
  int miscompares = 0;

  apu_pulse_array dut (
    .clk      (clk),
    .reset    (reset),
    .apu_tick (apu_tick),
    .qframe   (qframe),
    .hframe   (hframe),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .en       (en),
    .act      (act),
    .vol      (vol),
    .mix      (mix)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc(1);
    we = 1'b0;
  endtask

  // Timer ticks on n consecutive cycles, then one cycle for the output register.
  task automatic ticks(input int n);
    apu_tick = 1'b1;
    cyc(n);
    apu_tick = 1'b0;
    cyc(1);
  endtask

  task automatic qf();
    qframe = 1'b1;
    cyc(1);
    qframe = 1'b0;
    cyc(1);
  endtask

  // Half-frame always coincides with a quarter-frame.
  task automatic hf();
    qframe = 1'b1; hframe = 1'b1;
    cyc(1);
    qframe = 1'b0; hframe = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; apu_tick = 1'b0; qframe = 1'b0; hframe = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; en = 2'b01;
    cyc(2);
    check("reset_vol", 32'(vol), 32'h0);
    check("reset_act", 32'(act), 32'h0);
    check("reset_mix", 32'(mix), 32'h0);
    reset = 1'b0;
    cyc(1);

    // Tone: duty 2, halt, constant 15, period 0x010, length index 1.
    wr(3'd0, 8'hBF);
    wr(3'd2, 8'h10);
    wr(3'd3, 8'h08);
    cyc(1);
    check("tone_act", 32'(act), 32'h1);
    check("tone_vol_step0", 32'(vol), 32'h0F);
    check("tone_mix", 32'(mix), 32'd15);
    ticks(1);   // counter was 0: reload, step 0 -> 7 (low)
    check("tone_step7", 32'(vol[3:0]), 32'h0);
    ticks(67);  // steps advance every 17 ticks; now at step 4
    check("tone_step4", 32'(vol[3:0]), 32'h0);
    ticks(1);   // step 3 (high)
    check("tone_step3", 32'(vol[3:0]), 32'hF);

    // Duty 0 is high only at step 0; reg3 write must beat a same-cycle tick.
    wr(3'd0, 8'h3F);
    cyc(1);
    check("duty0_step3", 32'(vol[3:0]), 32'h0);
    we = 1'b1; addr = 3'd3; wdata = 8'h08; apu_tick = 1'b1;
    cyc(1);
    we = 1'b0; apu_tick = 1'b0;
    cyc(1);
    check("write_beats_tick", 32'(vol[3:0]), 32'hF);

    // Length counter: 254 half-frames with halt clear.
    wr(3'd0, 8'h1F);
    wr(3'd3, 8'h08);
    cyc(1);
    check("len_loaded", 32'(act[0]), 32'h1);
    for (int k = 0; k < 253; k++) hf();
    check("len_253", 32'(act[0]), 32'h1);
    check("len_253_vol", 32'(vol[3:0]), 32'hF);
    hf();
    check("len_254_act", 32'(act[0]), 32'h0);
    check("len_254_vol", 32'(vol[3:0]), 32'h0);

    // Disabling mid-count clears length; loads are blocked while disabled.
    wr(3'd3, 8'h08);
    for (int k = 0; k < 10; k++) hf();
    check("en_before", 32'(act[0]), 32'h1);
    en = 2'b00;
    cyc(2);
    check("en_clear", 32'(act[0]), 32'h0);
    wr(3'd3, 8'h08);
    cyc(1);
    check("en_block_load", 32'(act[0]), 32'h0);
    en = 2'b11;

    // Sweep negate: period 0x100, shift 1, sweep period 0.
    wr(3'd0, 8'hBF); wr(3'd1, 8'h89); wr(3'd2, 8'h00); wr(3'd3, 8'h09);
    wr(3'd4, 8'hBF); wr(3'd5, 8'h89); wr(3'd6, 8'h00); wr(3'd7, 8'h09);
    cyc(1);
    check("mix_two_ch", 32'(mix), 32'd30);
    check("vol_two_ch", 32'(vol), 32'hFF);
    check("act_two_ch", 32'(act), 32'h3);
    hf();
    check("sweep_ones", 32'(dut.g_ch[0].u_ch.period), 32'h07F);
    check("sweep_twos", 32'(dut.g_ch[1].u_ch.period), 32'h080);

    // Add sweep overflow on ch1 mutes and leaves the period alone.
    wr(3'd5, 8'h81); wr(3'd6, 8'hF0); wr(3'd7, 8'h0F);
    cyc(1);
    check("ovf_mute", 32'(vol[7:4]), 32'h0);
    hf();
    check("ovf_period", 32'(dut.g_ch[1].u_ch.period), 32'h7F0);
    check("ovf_mute_after", 32'(vol[7:4]), 32'h0);
    check("sweep_ones_2", 32'(dut.g_ch[0].u_ch.period), 32'h03F);

    // Period below 8 mutes regardless of sweep.
    wr(3'd6, 8'h07); wr(3'd7, 8'h08);
    cyc(1);
    check("p7_mute", 32'(vol[7:4]), 32'h0);
    check("p7_act", 32'(act[1]), 32'h1);
    hf();
    check("p7_period", 32'(dut.g_ch[1].u_ch.period), 32'h007);
    wr(3'd6, 8'h08);
    cyc(1);
    check("p8_unmute", 32'(vol[7:4]), 32'hF);

    // Envelope: loop, period 0 -> 15,14..0,15 on successive quarter-frames.
    wr(3'd0, 8'hA0); wr(3'd2, 8'h10); wr(3'd3, 8'h08);
    for (int k = 1; k <= 17; k++) begin
      qf();
      check($sformatf("env_q%0d", k), 32'(vol[3:0]), (k == 17) ? 32'd15 : 32'(16 - k));
    end

    // Reset during an active tone with length 20.
    wr(3'd0, 8'hBF); wr(3'd3, 8'h10);
    cyc(1);
    check("pre_reset_act", 32'(act[0]), 32'h1);
    check("pre_reset_vol", 32'(vol[3:0]), 32'hF);
    reset = 1'b1;
    cyc(1);
    check("mid_reset_vol", 32'(vol), 32'h0);
    check("mid_reset_act", 32'(act), 32'h0);
    check("mid_reset_mix", 32'(mix), 32'h0);
    reset = 1'b0;
    cyc(1);
    check("post_reset_period", 32'(dut.g_ch[0].u_ch.period), 32'h0);
    check("post_reset_len", 32'(dut.g_ch[0].u_ch.len), 32'h0);
    check("post_reset_act", 32'(act), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
